// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter sharing one 4-to-1 data mux among four requesters.
//   A hold limit forces rotation so no requester can starve the others.
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   req    in   [3:0] request per requester (bit0=a .. bit3=d)
//   a..d   in   [W-1:0] requester data
//   y      out  [W-1:0] selected data, 0 when no grant is active
//   valid  out  1 while a grant is active (== |gnt)
//   gnt    out  [3:0] registered one-hot grant, 0000 when idle
//   sel    out  [1:0] registered mux select (00=a .. 11=d)
module mux4_rr_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] y,
  output logic         valid,
  output logic [3:0]   gnt,
  output logic [1:0]   sel
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state, state_nx;
  logic [1:0]    ptr, ptr_nx, sel_nx;
  logic [3:0]    gnt_nx, others;
  logic          valid_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    pick_ptr, pick_next;

  // Returns {found, index} of the first set bit of r, searching
  // start, start+1, ... modulo 4. Walking k downwards lets the
  // lowest offset overwrite the result last and therefore win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      gnt   <= 4'b0000;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      sel   <= sel_nx;
      gnt   <= gnt_nx;
      valid <= valid_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    sel_nx    = sel;
    gnt_nx    = gnt;
    valid_nx  = valid;
    cnt_nx    = cnt;
    // Requests other than the current owner; on release this equals req.
    others    = req & ~(4'b0001 << sel);
    pick_ptr  = rr_pick(req, ptr);
    pick_next = rr_pick(others, sel + 2'd1);

    case (state)
      IDLE: begin
        if (pick_ptr[2]) begin
          state_nx = GRANT;
          sel_nx   = pick_ptr[1:0];
          gnt_nx   = 4'b0001 << pick_ptr[1:0];
          valid_nx = 1'b1;
          cnt_nx   = CNT_ONE;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          ptr_nx = sel + 2'd1;
          if (pick_next[2]) begin
            // Hand over on the same edge: no idle bubble between owners.
            sel_nx = pick_next[1:0];
            gnt_nx = 4'b0001 << pick_next[1:0];
            cnt_nx = CNT_ONE;
          end else begin
            // sel deliberately keeps its last value while idle.
            state_nx = IDLE;
            gnt_nx   = 4'b0000;
            valid_nx = 1'b0;
            cnt_nx   = '0;
          end
        end else if (cnt == CNT_MAX && pick_next[2]) begin
          ptr_nx = sel + 2'd1;
          sel_nx = pick_next[1:0];
          gnt_nx = 4'b0001 << pick_next[1:0];
          cnt_nx = CNT_ONE;
        end else if (cnt != CNT_MAX) begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    y = '0;
    if (valid) begin
      case (sel)
        2'd0:    y = a;
        2'd1:    y = b;
        2'd2:    y = c;
        default: y = d;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
//   Directed bench for mux4_rr_arbiter: reset, single requester,
//   round-robin hand-over, hold-limit rotation, wrap-around and async
//   reset during a grant. A negedge monitor checks gnt one-hot/zero,
//   valid==|gnt and the y mux every cycle.
module tb_mux4_rr_arbiter;

  localparam int W        = 8;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] a = 8'h11, b = 8'h22, c = 8'hA5, d = 8'h44;
  logic [W-1:0] y;
  logic         valid;
  logic [3:0]   gnt;
  logic [1:0]   sel;

  int n_checks = 0;
  int n_fail   = 0;

  mux4_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .y(y), .valid(valid), .gnt(gnt), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_y(input logic v, input logic [1:0] s);
    if (!v) return '0;
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  // Per-cycle invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("valid_eq_or_gnt", 32'(valid), 32'(|gnt));
      chk("y_mux", 32'(y), 32'(exp_y(valid, sel)));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Async pulse placed between edges.
  task automatic rst_pulse();
    req = 4'b0000;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  logic [3:0] rr_seq [4];
  logic [3:0] prev, exp_g;

  initial begin
    rr_seq[0] = 4'b0010; rr_seq[1] = 4'b0100;
    rr_seq[2] = 4'b1000; rr_seq[3] = 4'b0001;

    // 1: reset acts with no clock edge, even with all requests high
    #2 rst = 1'b1; req = 4'b1111;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    req = 4'b0000;
    step(2);
    rst = 1'b0;

    // 2: single requester c
    req = 4'b0100;
    step(1);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_sel", 32'(sel), 32'h2);
    chk("single_valid", 32'(valid), 32'h1);
    chk("single_y", 32'(y), 32'hA5);
    req = 4'b0000;
    step(1);
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_valid", 32'(valid), 32'h0);
    chk("idle_y", 32'(y), 32'h0);
    chk("idle_sel_hold", 32'(sel), 32'h2);

    // 3: round robin, each owner drops its request for one cycle
    rst_pulse();
    req = 4'b1111;
    step(1);
    chk("rr_first", 32'(gnt), 32'h1);
    prev = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      req = 4'b1111 & ~prev;
      step(1);
      chk("rr_gnt", 32'(gnt), 32'(rr_seq[i]));
      chk("rr_no_bubble", 32'(valid), 32'h1);
      prev = rr_seq[i];
    end

    // 4: hold limit with a and b both requesting continuously
    rst_pulse();
    req = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      step(1);
      exp_g = (((i / MAX_HOLD) % 2) == 0) ? 4'b0001 : 4'b0010;
      chk("hold_rotate", 32'(gnt), 32'(exp_g));
    end
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_alone", 32'(gnt), 32'h1);
    end

    // 5: wrap-around 3 -> 0, on release and on forced rotation
    rst_pulse();
    req = 4'b1000;
    step(1);
    chk("wrap_own3", 32'(gnt), 32'h8);
    req = 4'b0001;
    step(1);
    chk("wrap_release", 32'(gnt), 32'h1);
    chk("wrap_release_sel", 32'(sel), 32'h0);

    rst_pulse();
    req = 4'b1000;
    step(1);
    req = 4'b1001;
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      step(1);
      chk("wrap_hold3", 32'(gnt), 32'h8);
    end
    step(1);
    chk("wrap_forced", 32'(gnt), 32'h1);

    // 6: async reset in the middle of a grant
    rst_pulse();
    req = 4'b0100;
    step(1);
    chk("mid_pre_gnt", 32'(gnt), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("mid_gnt", 32'(gnt), 32'h0);
    chk("mid_valid", 32'(valid), 32'h0);
    chk("mid_sel", 32'(sel), 32'h0);
    chk("mid_y", 32'(y), 32'h0);
    #1 rst = 1'b0;
    req = 4'b1111;
    step(1);
    chk("mid_restart", 32'(gnt), 32'h1);

    req = 4'b0000;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
